// File: rtl/myfilter_pkg.sv
// Shared constants for the filter datapath and its output buffer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package myfilter_pkg;

    // Sample width carried through the filter datapath.
    localparam int DATABITS      = 16;

    // Output buffer sizing: entries and width of the dropped-sample counter.
    localparam int OUTFIFO_DEPTH = 4;
    localparam int DROPBITS      = 8;

endpackage : myfilter_pkg

// File: rtl/myfilter_outfifo.sv
// Output sample buffer: captures controller strobes into a show-ahead FIFO with level/overflow/drop status.
// Latency: a sample strobed at edge N is at the head (out_valid=1) from cycle N+1; no empty bypass.
// Backpressure: consumer stalls via out_ready; when full and not popping, new samples are dropped and counted.
module myfilter_outfifo
    import myfilter_pkg::*;
#(
    parameter int DATABITS = myfilter_pkg::DATABITS,
    parameter int DEPTH    = myfilter_pkg::OUTFIFO_DEPTH,
    parameter int DROPBITS = myfilter_pkg::DROPBITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       extvalid_in,
    input  logic [DATABITS-1:0]        din,
    input  logic                       flush_in,
    output logic                       out_valid,
    output logic [DATABITS-1:0]        out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [DROPBITS-1:0]        drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    // Storage and bookkeeping registers.
    logic [DATABITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wptr_q, wptr_d;
    logic [AW-1:0]       rptr_q, rptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic                overflow_q, overflow_d;
    logic [DROPBITS-1:0] drop_q, drop_d;

    logic full;
    logic pop;
    logic push;
    logic drop;
    logic clear;

    // Handshake decode. A pop frees a slot in the same cycle, so a full
    // buffer that is being drained still accepts the incoming sample.
    always_comb begin
        clear = rst | flush_in;
        full  = (level_q == FULL_LEVEL);
        pop   = (level_q != '0) & out_ready;
        push  = extvalid_in & (~full | pop);
        drop  = extvalid_in & full & ~pop;
    end

    // Next-state for pointers, fill level and loss status; clear wins over everything.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;

        if (clear) begin
            wptr_d     = '0;
            rptr_d     = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            // Pointers are AW bits wide and DEPTH is a power of two, so the
            // natural roll-over is the modulo-DEPTH wrap.
            if (push) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + AW'(1);
            end

            if (push && !pop) begin
                level_d = level_q + LW'(1);
            end else if (pop && !push) begin
                level_d = level_q - LW'(1);
            end

            if (drop) begin
                overflow_d = 1'b1;
                if (drop_q != '1) begin
                    drop_d = drop_q + DROPBITS'(1);
                end
            end
        end
    end

    // Register control state; reset behaves exactly like a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Sample storage is not reset; writes are suppressed while clearing so a
    // strobe coinciding with flush leaves no trace.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_q[wptr_q] <= din;
        end
    end

    // Head and status come straight from registers: no input-to-output path.
    always_comb begin
        out_valid  = (level_q != '0);
        out_data   = mem_q[rptr_q];
        level      = level_q;
        overflow   = overflow_q;
        drop_count = drop_q;
    end

endmodule : myfilter_outfifo
